asrm_periph_arbiter: RTL and testbench

// - Shares the single peripheral register bus (enable/addr/data_in/write_en -> OR-ed data_out) between N bus masters (CPU, DMA, debug).
// - Round-robin arbitration; sequences each access to match the registered, 1-cycle read latency of the peripheral registers.
// - Sits between the masters and the peripheral address decoder; peripherals are unchanged.

---
 rtl/asrm_bus_pkg.sv | 20 ++
 rtl/asrm_periph_arbiter_if.sv | 36 +++
 rtl/asrm_rr_picker.sv | 34 +++
 rtl/asrm_periph_arbiter.sv | 143 ++++++++++++++
 tb/tb_asrm_periph_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/asrm_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM state encoding,
// default widths and the pointer-width helper.
package asrm_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    localparam int DEF_N_MASTERS = 2;
    localparam int DEF_ADDR_SIZE = 16;
    localparam int DEF_WORD_SIZE = 8;

    // Width of a master index; never below one bit so a 1-master build still elaborates.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/asrm_periph_arbiter_if.sv
// Bundle of the per-master request signals and the shared peripheral register bus.
// The master modport is the arbiter's view (it masters the peripheral bus); slave is everyone else.
interface asrm_periph_arbiter_if
    import asrm_bus_pkg::*;
#(
    parameter int n_masters = DEF_N_MASTERS,
    parameter int addr_size = DEF_ADDR_SIZE,
    parameter int word_size = DEF_WORD_SIZE
);

    logic [n_masters-1:0]           m_req;
    logic [n_masters-1:0]           m_lock;
    logic [n_masters-1:0]           m_write;
    logic [n_masters*addr_size-1:0] m_addr;
    logic [n_masters*word_size-1:0] m_wdata;
    logic [n_masters-1:0]           m_ack;
    logic [word_size-1:0]           m_rdata;
    logic [n_masters-1:0]           m_grant;

    logic                           p_enable;
    logic                           p_write_en;
    logic [addr_size-1:0]           p_addr;
    logic [word_size-1:0]           p_data_in;
    logic [word_size-1:0]           p_data_out;

    modport master (
        input  m_req, m_lock, m_write, m_addr, m_wdata, p_data_out,
        output m_ack, m_rdata, m_grant, p_enable, p_write_en, p_addr, p_data_in
    );

    modport slave (
        output m_req, m_lock, m_write, m_addr, m_wdata, p_data_out,
        input  m_ack, m_rdata, m_grant, p_enable, p_write_en, p_addr, p_data_in
    );

endinterface

// File: rtl/asrm_rr_picker.sv
// Combinational round-robin select: first requester at or after rr_ptr, wrapping to 0.
module asrm_rr_picker #(
    parameter int n_masters = 2,
    parameter int ptr_w     = 1
) (
    input  logic [n_masters-1:0] req,
    input  logic [ptr_w-1:0]     rr_ptr,
    output logic [n_masters-1:0] grant_onehot,
    output logic [ptr_w-1:0]     grant_idx,
    output logic                 valid
);

    // First pass looks at indices >= rr_ptr, the second pass supplies the wrap-around.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        valid        = 1'b0;
        for (int i = 0; i < n_masters; i++) begin
            if (!valid && req[i] && (ptr_w'(i) >= rr_ptr)) begin
                valid           = 1'b1;
                grant_idx       = ptr_w'(i);
                grant_onehot[i] = 1'b1;
            end
        end
        for (int i = 0; i < n_masters; i++) begin
            if (!valid && req[i]) begin
                valid           = 1'b1;
                grant_idx       = ptr_w'(i);
                grant_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/asrm_periph_arbiter.sv
// Round-robin arbiter sharing one registered-read peripheral bus between several masters.
// Each access runs IDLE -> ACCESS -> COMPLETE; a locked owner may chain straight back into ACCESS.
module asrm_periph_arbiter
    import asrm_bus_pkg::*;
#(
    parameter int n_masters = DEF_N_MASTERS,
    parameter int addr_size = DEF_ADDR_SIZE,
    parameter int word_size = DEF_WORD_SIZE
) (
    input logic                   clk,
    input logic                   reset,
    asrm_periph_arbiter_if.master bus
);

    localparam int ptr_w = ptr_width(n_masters);

    state_t               state;
    state_t               next_state;

    logic [n_masters-1:0] grant_q;
    logic [ptr_w-1:0]     owner_q;
    logic [ptr_w-1:0]     rr_ptr;
    logic [addr_size-1:0] addr_q;
    logic [word_size-1:0] wdata_q;
    logic                 write_q;

    logic [n_masters-1:0] pick_onehot;
    logic [ptr_w-1:0]     pick_idx;
    logic                 pick_valid;

    logic [ptr_w-1:0]     sel_idx;
    logic [addr_size-1:0] sel_addr;
    logic [word_size-1:0] sel_wdata;
    logic                 sel_write;
    logic                 keep_grant;
    logic [ptr_w-1:0]     next_ptr;

    asrm_rr_picker #(
        .n_masters (n_masters),
        .ptr_w     (ptr_w)
    ) u_picker (
        .req          (bus.m_req),
        .rr_ptr       (rr_ptr),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .valid        (pick_valid)
    );

    // In IDLE the latch source is the newly picked master; in COMPLETE it is the locked owner.
    always_comb begin
        sel_idx    = (state == ST_IDLE) ? pick_idx : owner_q;
        sel_addr   = '0;
        sel_wdata  = '0;
        sel_write  = 1'b0;
        for (int i = 0; i < n_masters; i++) begin
            if (sel_idx == ptr_w'(i)) begin
                sel_addr  = bus.m_addr[i*addr_size +: addr_size];
                sel_wdata = bus.m_wdata[i*word_size +: word_size];
                sel_write = bus.m_write[i];
            end
        end
        keep_grant = bus.m_lock[owner_q] && bus.m_req[owner_q];
        next_ptr   = (owner_q == ptr_w'(n_masters - 1)) ? '0 : owner_q + ptr_w'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (pick_valid) next_state = ST_ACCESS;
            ST_ACCESS:   next_state = ST_COMPLETE;
            ST_COMPLETE: next_state = keep_grant ? ST_ACCESS : ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // Grant, owner, pointer and the latched request; the pointer only moves when the grant is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= '0;
            owner_q <= '0;
            rr_ptr  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_onehot;
                        owner_q <= pick_idx;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        write_q <= sel_write;
                    end
                end
                ST_COMPLETE: begin
                    if (keep_grant) begin
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        write_q <= sel_write;
                    end else begin
                        grant_q <= '0;
                        rr_ptr  <= next_ptr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Peripherals register their read data, so it is passed through only in the COMPLETE cycle.
    always_comb begin
        bus.m_ack      = '0;
        bus.m_rdata    = '0;
        bus.m_grant    = grant_q;
        bus.p_enable   = 1'b0;
        bus.p_write_en = 1'b0;
        bus.p_addr     = '0;
        bus.p_data_in  = '0;
        case (state)
            ST_ACCESS: begin
                bus.p_enable   = 1'b1;
                bus.p_write_en = write_q;
                bus.p_addr     = addr_q;
                bus.p_data_in  = wdata_q;
            end
            ST_COMPLETE: begin
                bus.m_ack   = grant_q;
                bus.m_rdata = write_q ? '0 : bus.p_data_out;
            end
            default: bus.m_grant = '0;
        endcase
    end

endmodule

// File: tb/tb_asrm_periph_arbiter.sv
// Bench for asrm_periph_arbiter with three masters: directed scenarios plus randomized
// transaction batches checked against a transaction-level round-robin model.
module tb_asrm_periph_arbiter;
    import asrm_bus_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 8;

    typedef struct packed {
        logic          write;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct packed {
        int            idx;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    bit   mem_ready = 1'b0;

    int   vectors = 0;
    int   miscompares = 0;
    int   model_ptr = 0;

    logic [DW-1:0] pmem [256];
    logic [DW-1:0] gmem [256];
    txn_t          mq [N][$];
    exp_t          expq [$];
    int            ack_idx_log [$];
    int            ack_cyc_log [$];

    always #5 clk = ~clk;

    asrm_periph_arbiter_if #(.n_masters(N), .addr_size(AW), .word_size(DW)) bus ();

    asrm_periph_arbiter #(.n_masters(N), .addr_size(AW), .word_size(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] pattern(input int a);
        return DW'(a * 8'h13 + 8'h0E);
    endfunction

    // Peripheral register file: writes and reads are sampled at the edge ending ACCESS.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int a = 0; a < 256; a++) pmem[a] <= pattern(a);
            mem_ready <= 1'b1;
        end else if (bus.p_enable && bus.p_write_en) begin
            pmem[bus.p_addr[7:0]] <= bus.p_data_in;
        end
        bus.p_data_out <= (bus.p_enable && !bus.p_write_en) ? pmem[bus.p_addr[7:0]] : '0;
    end

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({bus.m_grant, bus.m_ack, bus.m_rdata, bus.p_enable,
                    bus.p_write_en, bus.p_addr, bus.p_data_in});
    endfunction

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic req, input logic lock, input logic write,
                                  input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.m_req[i]            = req;
        bus.m_lock[i]           = lock;
        bus.m_write[i]          = write;
        bus.m_addr[i*AW +: AW]  = addr;
        bus.m_wdata[i*DW +: DW] = wdata;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < N; i++) apply_stimulus(i, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #2;
        check_output("reset_outputs", all_outs(), 64'd0);
        reset = 1'b1;
        model_ptr = 0;
    endtask

    // One access from a lone requester, checking every cycle of its IDLE->ACCESS->COMPLETE walk.
    task automatic do_single(input int idx, input logic write, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input bit pulse);
        logic [DW-1:0] exp_r;
        exp_r = write ? '0 : gmem[addr[7:0]];
        if (write) gmem[addr[7:0]] = wdata;
        apply_stimulus(idx, 1'b1, 1'b0, write, addr, wdata);
        tick();
        check_output("single_access_bus", 64'({bus.p_enable, bus.p_write_en, bus.p_addr, bus.p_data_in}),
                     64'({1'b1, write, addr, wdata}));
        check_output("single_access_grant", 64'({bus.m_grant, bus.m_ack, bus.m_rdata}),
                     64'({onehot(idx), {N{1'b0}}, {DW{1'b0}}}));
        if (pulse) apply_stimulus(idx, 1'b0, 1'b0, write, addr, wdata);
        tick();
        check_output("single_ack", 64'({bus.m_ack, bus.m_rdata}), 64'({onehot(idx), exp_r}));
        check_output("single_complete_bus", 64'({bus.p_enable, bus.p_write_en, bus.p_addr, bus.p_data_in}), 64'd0);
        apply_stimulus(idx, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        check_output("single_release", all_outs(), 64'd0);
        model_ptr = (idx + 1) % N;
    endtask

    // Drives the queued transactions in mq, master by master, and scores acks against the model.
    task automatic run_engine(input int max_cycles);
        txn_t tq [N][$];
        txn_t t;
        exp_t e;
        int   p, cont, sel, remaining, acked;
        logic prev_en;

        expq.delete();
        for (int i = 0; i < N; i++) tq[i] = mq[i];
        p = model_ptr;
        cont = -1;
        while (1) begin
            remaining = 0;
            for (int i = 0; i < N; i++) remaining += tq[i].size();
            if (remaining == 0) break;
            if (cont >= 0) begin
                sel = cont;
            end else begin
                sel = -1;
                for (int k = 0; k < N; k++)
                    if (sel < 0 && tq[(p + k) % N].size() > 0) sel = (p + k) % N;
            end
            t = tq[sel].pop_front();
            e.idx = sel;
            e.write = t.write;
            e.addr = t.addr;
            e.wdata = t.wdata;
            if (t.write) begin
                gmem[t.addr[7:0]] = t.wdata;
                e.rdata = '0;
            end else begin
                e.rdata = gmem[t.addr[7:0]];
            end
            expq.push_back(e);
            if (t.lock && tq[sel].size() > 0) begin
                cont = sel;
            end else begin
                cont = -1;
                p = (sel + 1) % N;
            end
        end
        model_ptr = p;

        for (int i = 0; i < N; i++) begin
            if (mq[i].size() > 0)
                apply_stimulus(i, 1'b1, mq[i][0].lock, mq[i][0].write, mq[i][0].addr, mq[i][0].wdata);
            else
                apply_stimulus(i, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        ack_idx_log.delete();
        ack_cyc_log.delete();
        prev_en = 1'b0;

        for (int cyc = 0; cyc < max_cycles && expq.size() > 0; cyc++) begin
            tick();
            check_output("grant_onehot0", 64'($onehot0(bus.m_grant)), 64'd1);
            check_output("ack_onehot0", 64'($onehot0(bus.m_ack)), 64'd1);
            check_output("enable_spacing", 64'(bus.p_enable & (prev_en | (|bus.m_ack))), 64'd0);
            prev_en = bus.p_enable;
            if (bus.p_enable) begin
                e = expq[0];
                check_output("access_fields",
                             64'({bus.m_grant, bus.p_write_en, bus.p_addr, bus.p_data_in}),
                             64'({onehot(e.idx), e.write, e.addr, e.wdata}));
            end
            acked = -1;
            if (|bus.m_ack) begin
                for (int i = 0; i < N; i++) if (bus.m_ack[i]) acked = i;
                e = expq.pop_front();
                check_output("ack_master_rdata", 64'({32'(acked), bus.m_rdata}),
                             64'({32'(e.idx), e.rdata}));
                ack_idx_log.push_back(acked);
                ack_cyc_log.push_back(cyc);
                if (mq[acked].size() > 0) void'(mq[acked].pop_front());
                if (mq[acked].size() > 0)
                    apply_stimulus(acked, 1'b1, bus.m_lock[acked], mq[acked][0].write,
                                   mq[acked][0].addr, mq[acked][0].wdata);
                else
                    apply_stimulus(acked, 1'b0, bus.m_lock[acked], 1'b0, '0, '0);
            end
            for (int i = 0; i < N; i++)
                if (i != acked) bus.m_lock[i] = (mq[i].size() > 0) ? mq[i][0].lock : 1'b0;
        end
        check_output("engine_all_acked", 64'(expq.size()), 64'd0);
        clear_inputs();
        for (int i = 0; i < N; i++) mq[i].delete();
        tick();
        check_output("engine_drain", 64'({bus.m_grant, bus.m_ack, bus.p_enable}), 64'd0);
    endtask

    initial begin
        txn_t t;
        for (int a = 0; a < 256; a++) gmem[a] = pattern(a);
        clear_inputs();
        bus.p_data_out = '0;

        do_reset();

        $display("[TB] idle bus");
        for (int c = 0; c < 10; c++) begin
            tick();
            check_output("idle_outputs", all_outs(), 64'd0);
        end

        $display("[TB] single read, write, pulsed request");
        do_single(0, 1'b0, 16'h0004, 8'h00, 1'b0);
        do_single(1, 1'b1, 16'h0010, 8'hC3, 1'b0);
        do_single(2, 1'b0, 16'h0010, 8'h00, 1'b1);
        tick();
        check_output("pulse_single_ack", 64'(bus.m_ack), 64'd0);

        $display("[TB] reset during access");
        do_single(0, 1'b0, 16'h0005, 8'h00, 1'b0);
        apply_stimulus(1, 1'b1, 1'b0, 1'b0, 16'h0006, 8'h00);
        tick();
        check_output("pre_reset_access", 64'({bus.p_enable, bus.m_grant}), 64'({1'b1, onehot(1)}));
        reset = 1'b0;
        #1;
        check_output("reset_async_outputs", all_outs(), 64'd0);
        clear_inputs();
        tick();
        check_output("reset_no_ack", all_outs(), 64'd0);
        reset = 1'b1;
        apply_stimulus(0, 1'b1, 1'b0, 1'b0, 16'h0007, 8'h00);
        apply_stimulus(1, 1'b1, 1'b0, 1'b0, 16'h0006, 8'h00);
        tick();
        check_output("post_reset_grant", 64'(bus.m_grant), 64'(onehot(0)));
        tick();
        check_output("post_reset_ack0", 64'({bus.m_ack, bus.m_rdata}), 64'({onehot(0), gmem[7]}));
        apply_stimulus(0, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        check_output("post_reset_grant1", 64'(bus.m_grant), 64'(onehot(1)));
        tick();
        check_output("post_reset_ack1", 64'({bus.m_ack, bus.m_rdata}), 64'({onehot(1), gmem[6]}));
        clear_inputs();
        tick();

        $display("[TB] contention");
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 2; k++) begin
                t.write = 1'b0;
                t.lock  = 1'b0;
                t.addr  = AW'(i * 4 + k);
                t.wdata = '0;
                mq[i].push_back(t);
            end
        run_engine(200);
        check_output("contention_ack_count", 64'(ack_idx_log.size()), 64'd6);
        if (ack_idx_log.size() == 6)
            for (int k = 0; k < 6; k++)
                check_output("contention_order", 64'(ack_idx_log[k]), 64'(k % 3));

        $display("[TB] locked sequence");
        do_single(0, 1'b0, 16'h0001, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            t.write = 1'b0;
            t.lock  = 1'b1;
            t.addr  = AW'(8 + k);
            t.wdata = '0;
            mq[1].push_back(t);
        end
        t.lock = 1'b0;
        t.addr = 16'h000C;
        mq[0].push_back(t);
        run_engine(200);
        check_output("lock_ack_count", 64'(ack_idx_log.size()), 64'd4);
        if (ack_idx_log.size() == 4) begin
            check_output("lock_order", 64'({ack_idx_log[0][3:0], ack_idx_log[1][3:0],
                                            ack_idx_log[2][3:0], ack_idx_log[3][3:0]}), 64'h1110);
            check_output("lock_spacing_a", 64'(ack_cyc_log[1] - ack_cyc_log[0]), 64'd2);
            check_output("lock_spacing_b", 64'(ack_cyc_log[2] - ack_cyc_log[1]), 64'd2);
        end

        $display("[TB] randomized batches");
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                int cnt;
                cnt = $urandom_range(0, 3);
                for (int k = 0; k < cnt; k++) begin
                    t.write = 1'($urandom_range(0, 1));
                    t.lock  = ($urandom_range(0, 2) == 0);
                    t.addr  = AW'($urandom_range(0, 15));
                    t.wdata = DW'($urandom);
                    mq[i].push_back(t);
                end
            end
            run_engine(400);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
